// File: rtl/contador_pkg.sv
// Shared defaults and sat_mode encoding for the contador_teclas key counter.
package contador_pkg;

  localparam int NUM_KEYS_DEF   = 4;
  localparam int CNT_W_DEF      = 4;
  localparam int DEB_CYCLES_DEF = 4;

  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

endpackage

// File: rtl/contador_teclas_antirrebote.sv
// antirrebote: single-bit debouncer, two-flop synchronizer followed by a
// stable-sample counter; the output follows the input only after DEB_CYCLES agreeing samples.
module antirrebote #(
  parameter int DEB_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic level
);

  localparam int RUN_W = $clog2(DEB_CYCLES);

  logic             sync1;
  logic             sync2;
  logic [RUN_W-1:0] run;

  // run counts consecutive synchronized samples that disagree with level
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      run   <= '0;
      level <= 1'b0;
    end else begin
      sync1 <= key;
      sync2 <= sync1;
      if (sync2 == level) begin
        run <= '0;
      end else if (run == RUN_W'(DEB_CYCLES - 1)) begin
        level <= sync2;
        run   <= '0;
      end else begin
        run <= run + RUN_W'(1);
      end
    end
  end

endmodule

// File: rtl/contador_teclas.sv
// contador_teclas: per-key press counters with edge detection, wrap/saturate and
// sticky overflow. Define CONTADOR_TECLAS_DEBOUNCE_EN to insert an antirrebote per key.
module contador_teclas
  import contador_pkg::*;
#(
  parameter int NUM_KEYS   = NUM_KEYS_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_KEYS-1:0]       key_state,
  input  logic                      clear,
  input  logic                      sat_mode,
  output logic [NUM_KEYS*CNT_W-1:0] counts,
  output logic [NUM_KEYS-1:0]       press_pulse,
  output logic [NUM_KEYS-1:0]       overflow
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  if (NUM_KEYS < 1 || NUM_KEYS > 16 || CNT_W < 2 || CNT_W > 16 ||
      DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_param_check
    $error("contador_teclas: parameter out of range");
  end

  logic [NUM_KEYS-1:0] level;
  logic [NUM_KEYS-1:0] level_q;
  logic [NUM_KEYS-1:0] rise;

`ifdef CONTADOR_TECLAS_DEBOUNCE_EN
  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_deb
    antirrebote #(.DEB_CYCLES(DEB_CYCLES)) u_antirrebote (
      .clk   (clk),
      .reset (reset),
      .key   (key_state[g]),
      .level (level[g])
    );
  end
`else
  logic [NUM_KEYS-1:0] sync1;
  logic [NUM_KEYS-1:0] sync2;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= key_state;
      sync2 <= sync1;
    end
  end

  assign level = sync2;
`endif

  assign rise = level & ~level_q;

  // clear wins over a coincident press, yet the press is still strobed
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      level_q     <= '0;
      press_pulse <= '0;
      counts      <= '0;
      overflow    <= '0;
    end else begin
      level_q     <= level;
      press_pulse <= rise;
      if (clear) begin
        counts   <= '0;
        overflow <= '0;
      end else begin
        for (int i = 0; i < NUM_KEYS; i++) begin
          if (rise[i]) begin
            if (counts[i*CNT_W +: CNT_W] == CNT_MAX) begin
              overflow[i] <= 1'b1;
              if (sat_mode == MODE_WRAP) begin
                counts[i*CNT_W +: CNT_W] <= '0;
              end
            end else begin
              counts[i*CNT_W +: CNT_W] <= counts[i*CNT_W +: CNT_W] + CNT_W'(1);
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/contador_teclas.md
CONTADOR_TECLAS -- requirements
Module: contador_teclas

Interface
REQ-001 Parameter NUM_KEYS, default 4, number of independent key channels (1..16).
REQ-002 Parameter CNT_W, default 4, width of each per-key press counter (2..16).
REQ-003 Parameter DEB_CYCLES, default 4, number of consecutive stable samples required by the debouncer (2..255).
REQ-004 clk  input  1  single system clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset; asserted when 0.
REQ-006 key_state  input  NUM_KEYS  raw, asynchronous key levels; 1 = pressed.
REQ-007 clear  input  1  synchronous clear of all counters and overflow flags.
REQ-008 sat_mode  input  1  1 = counters saturate at maximum; 0 = counters wrap to 0.
REQ-009 counts  output  NUM_KEYS*CNT_W  packed counters; key i occupies bits [i*CNT_W +: CNT_W].
REQ-010 press_pulse  output  NUM_KEYS  one-cycle strobe per detected press.
REQ-011 overflow  output  NUM_KEYS  sticky flag per key; set when the key's counter reaches its maximum and is pressed again.

Function
REQ-012 Each key bit SHALL pass through a two-flop synchronizer before any other logic.
REQ-013 A press SHALL be a 0->1 transition of the conditioned (synchronized, optionally debounced) key level; releases SHALL NOT count.
REQ-014 Without debounce, counts[i] and press_pulse[i] SHALL update on the 3rd rising clk edge after key_state[i] rises (input set up before the 1st edge).
REQ-015 press_pulse[i] SHALL be high for exactly one cycle per press, coincident with the counter increment.
REQ-016 Key channels SHALL be fully independent; simultaneous presses on any subset SHALL each increment once in the same cycle.
REQ-017 Wrap mode: a press at 2^CNT_W-1 SHALL yield 0 and set overflow[i].
REQ-018 Saturate mode: a press at 2^CNT_W-1 SHALL hold the value and set overflow[i].
REQ-019 overflow[i] SHALL remain set until clear or reset.
REQ-020 clear SHALL, on the next edge, zero all counts and overflow flags; it SHALL take priority over a simultaneous press, but press_pulse SHALL still assert for that press.
REQ-021 A key held continuously SHALL count exactly once.
REQ-022 sat_mode changes SHALL apply from the next press; existing counter values SHALL NOT be altered.

Reset
REQ-023 While reset=0: counts, press_pulse, overflow, synchronizer, edge-detect and debounce state SHALL all be 0.
REQ-024 A key held through reset release SHALL count once after propagating through the conditioning logic.
REQ-025 Reset asserted mid-operation SHALL abort any in-progress debounce count and discard any pending press.

Configuration
REQ-026 Macro CONTADOR_TECLAS_DEBOUNCE_EN SHALL control the debouncer.
REQ-027 When it is defined, the conditioned level SHALL change only after DEB_CYCLES consecutive synchronized samples differ from the current stable level. Pulses shorter than DEB_CYCLES cycles SHALL be ignored. Press latency SHALL be 3+DEB_CYCLES edges.
REQ-028 When it is undefined, the conditioned level SHALL be the synchronizer output, DEB_CYCLES SHALL be unused, and no debounce logic SHALL be instantiated.

Structure
REQ-029 Package contador_pkg SHALL hold the default values of NUM_KEYS, CNT_W and DEB_CYCLES, plus the sat_mode encoding constants MODE_WRAP=0 and MODE_SAT=1.
REQ-030 Sub-module antirrebote, a single-bit debouncer containing a synchronizer and a stable-sample counter, SHALL be generated once per key when CONTADOR_TECLAS_DEBOUNCE_EN is defined.

Verification (defaults; debounce off unless stated)
REQ-031 Stimulus: reset, then key0 pulsed 2x, key1 1x, keys 2 and 3 together 1x (each pulse 2 cycles high). Response: counts = {1,1,1,2} (key3..key0); 5 press_pulse strobes total.
REQ-032 Stimulus: wrap mode, key0 pressed 16x. Response: count0=0 and overflow[0]=1; other channels 0.
REQ-033 Stimulus: saturate mode, key0 pressed 17x. Response: count0=15 and overflow[0]=1.
REQ-034 Stimulus: clear asserted in the same cycle as key1's detected edge. Response: count1=0, press_pulse[1]=1, overflow all 0.
REQ-035 Stimulus: key2 held through reset release. Response: count2=1 after 3 edges, and it stays 1 while held.
REQ-036 Stimulus: debounce on with DEB_CYCLES=4; a 3-cycle glitch, then a 10-cycle press on key3. Response: count3=1, with press_pulse 7 edges after the press starts.
